// File: rtl/ppt_sequencer.sv
// ppt_sequencer -- programmable pulse-train sequencer.
//
// Generates bursts of HIGH_LEN-high / LOW_LEN-low periods on pulse_out, timed in
// units of the external tick enable. A burst is started from IDLE by a CTRL write
// with bit0 set, or by trig while ARM is set. COUNT=0 runs until abort.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset
//   tick       - time-base enable; burst timers only advance when high
//   cfg_we     - register write strobe
//   cfg_addr   - register address (0 HIGH_LEN, 1 LOW_LEN, 2 COUNT, 3 CTRL, 4 SENT)
//   cfg_wdata  - register write data
//   cfg_rdata  - combinational readback of the register at cfg_addr
//   trig       - external start request (already synchronized), gated by ARM
//   abort      - stop request, returns to IDLE without done
//   pulse_out  - registered pulse output, high exactly while in HIGH
//   busy       - high while a burst is running
//   done       - one-cycle strobe when a finite burst completes
module ppt_sequencer #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_addr,
    input  logic [LEN_W-1:0] cfg_wdata,
    output logic [LEN_W-1:0] cfg_rdata,
    input  logic             trig,
    input  logic             abort,
    output logic             pulse_out,
    output logic             busy,
    output logic             done
);

    localparam logic [LEN_W-1:0] ZERO_C = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] ONE_C  = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    // A programmed length of 0 behaves as 1 so every phase lasts at least one tick.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        eff_len = (len == ZERO_C) ? ONE_C : len;
    endfunction

    // A timer at 0 can only come from corruption; treat it as expired so the FSM
    // can never stall in HIGH or LOW.
    function automatic logic timer_expired(input logic [LEN_W-1:0] t);
        timer_expired = (t == ONE_C) || (t == ZERO_C);
    endfunction

    // Programmed (host-visible) registers
    logic [LEN_W-1:0] high_len_r;
    logic [LEN_W-1:0] low_len_r;
    logic [LEN_W-1:0] count_r;
    logic             arm_r;
    logic [LEN_W-1:0] sent_r;

    // Per-burst snapshots so host writes during a burst only affect the next one
    logic [LEN_W-1:0] sh_high_r;
    logic [LEN_W-1:0] sh_low_r;
    logic [LEN_W-1:0] sh_count_r;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [LEN_W-1:0] timer_r;
    logic [LEN_W-1:0] timer_nxt_s;
    logic [LEN_W-1:0] sent_nxt_s;
    logic [LEN_W-1:0] sent_inc_s;
    logic             done_nxt_s;
    logic             load_shadow_s;
    logic             pulse_r;
    logic             done_r;
    logic             ctrl_start_s;
    logic             start_s;
    logic             busy_s;

    assign ctrl_start_s = cfg_we && (cfg_addr == 3'd3) && cfg_wdata[0];
    assign start_s      = ctrl_start_s || (arm_r && trig);
    assign sent_inc_s   = sent_r + ONE_C;
    assign busy_s       = (state_r != ST_IDLE);

    assign pulse_out = pulse_r;
    assign busy      = busy_s;
    assign done      = done_r;

    // Next-state, timer, SENT and done decode for the burst FSM
    always_comb begin
        state_nxt_s   = state_r;
        timer_nxt_s   = timer_r;
        sent_nxt_s    = sent_r;
        done_nxt_s    = 1'b0;
        load_shadow_s = 1'b0;
        if (abort) begin
            // Abort wins over everything, including a start in the same cycle.
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_nxt_s   = ST_HIGH;
                        timer_nxt_s   = eff_len(high_len_r);
                        sent_nxt_s    = ZERO_C;
                        load_shadow_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_HIGH: begin
                    if (tick) begin
                        if (timer_expired(timer_r)) begin
                            state_nxt_s = ST_LOW;
                            timer_nxt_s = eff_len(sh_low_r);
                        end else begin
                            timer_nxt_s = timer_r - ONE_C;
                        end
                    end else begin
                        timer_nxt_s = timer_r;
                    end
                end
                ST_LOW: begin
                    if (tick) begin
                        if (timer_expired(timer_r)) begin
                            sent_nxt_s = sent_inc_s;
                            if ((sh_count_r != ZERO_C) && (sent_inc_s == sh_count_r)) begin
                                state_nxt_s = ST_IDLE;
                                done_nxt_s  = 1'b1;
                            end else begin
                                state_nxt_s = ST_HIGH;
                                timer_nxt_s = eff_len(sh_high_r);
                            end
                        end else begin
                            timer_nxt_s = timer_r - ONE_C;
                        end
                    end else begin
                        timer_nxt_s = timer_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state, timer, SENT and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            timer_r <= ZERO_C;
            sent_r  <= ZERO_C;
            pulse_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            timer_r <= timer_nxt_s;
            sent_r  <= sent_nxt_s;
            // Registering the decoded next state keeps pulse_out aligned with HIGH.
            pulse_r <= (state_nxt_s == ST_HIGH);
            done_r  <= done_nxt_s;
        end
    end

    // Shadow snapshot of the programmed lengths and count at burst start
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_high_r  <= ZERO_C;
            sh_low_r   <= ZERO_C;
            sh_count_r <= ZERO_C;
        end else if (load_shadow_s) begin
            sh_high_r  <= high_len_r;
            sh_low_r   <= low_len_r;
            sh_count_r <= count_r;
        end else begin
            sh_high_r  <= sh_high_r;
            sh_low_r   <= sh_low_r;
            sh_count_r <= sh_count_r;
        end
    end

    // Host register writes; accepted at any time, visible immediately on readback
    always_ff @(posedge clk) begin
        if (rst) begin
            high_len_r <= ZERO_C;
            low_len_r  <= ZERO_C;
            count_r    <= ZERO_C;
            arm_r      <= 1'b0;
        end else if (cfg_we) begin
            case (cfg_addr)
                3'd0:    high_len_r <= cfg_wdata;
                3'd1:    low_len_r  <= cfg_wdata;
                3'd2:    count_r    <= cfg_wdata;
                3'd3:    arm_r      <= cfg_wdata[1];
                default: arm_r      <= arm_r;
            endcase
        end else begin
            arm_r <= arm_r;
        end
    end

    // Combinational readback mux; CTRL reads as {busy, 0..., ARM}
    always_comb begin
        cfg_rdata = ZERO_C;
        case (cfg_addr)
            3'd0:    cfg_rdata = high_len_r;
            3'd1:    cfg_rdata = low_len_r;
            3'd2:    cfg_rdata = count_r;
            3'd3: begin
                cfg_rdata[LEN_W-1] = busy_s;
                cfg_rdata[0]       = arm_r;
            end
            3'd4:    cfg_rdata = sent_r;
            default: cfg_rdata = ZERO_C;
        endcase
    end

endmodule

// File: tb/tb_ppt_sequencer.sv
// Self-checking bench for ppt_sequencer: a table of register write/readback
// vectors followed by hand-written multi-cycle burst sequences.
module tb_ppt_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b1;
    logic       cfg_we = 1'b0;
    logic [2:0] cfg_addr = 3'd0;
    logic [7:0] cfg_wdata = 8'd0;
    logic [7:0] cfg_rdata;
    logic       trig = 1'b0;
    logic       abort = 1'b0;
    logic       pulse_out;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;
    int tick_div = 1;
    int tick_phase = 0;

    typedef struct packed {
        logic       we;
        logic [2:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp;
    } reg_vec_t;

    reg_vec_t vecs [10];

    ppt_sequencer #(.LEN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .trig      (trig),
        .abort     (abort),
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; tick pattern repeats every tick_div cycles.
    task automatic step();
        @(posedge clk);
        #1;
        if (tick_div > 1) begin
            tick_phase = (tick_phase + 1) % tick_div;
            tick = (tick_phase == 0);
        end else begin
            tick = 1'b1;
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic rd(input string name, input logic [2:0] a, input logic [7:0] exp);
        cfg_addr = a;
        #1;
        chk(name, cfg_rdata, exp);
    endtask

    // CTRL write; tick is aligned so the first tick after start lands tick_div cycles later.
    task automatic start_ctrl(input logic [7:0] v);
        tick = 1'b1;
        tick_phase = 0;
        wr(3'd3, v);
    endtask

    // Check a finite burst from the first HIGH cycle through the done strobe.
    // h/l are effective lengths in ticks, n periods, d cycles per tick.
    task automatic run_burst(input int h, input int l, input int n, input int d,
                             input logic mid_wr, input logic [2:0] wa, input logic [7:0] wd);
        int per;
        per = (h + l) * d;
        for (int k = 0; k < n * per; k++) begin
            chk("burst_pulse", pulse_out, ((k % per) < (h * d)) ? 32'd1 : 32'd0);
            chk("burst_busy", busy, 32'd1);
            chk("burst_done_early", done, 32'd0);
            if (k == 0 && mid_wr) begin
                cfg_we = 1'b1; cfg_addr = wa; cfg_wdata = wd;
            end
            step();
            cfg_we = 1'b0;
        end
        chk("end_done", done, 32'd1);
        chk("end_busy", busy, 32'd0);
        chk("end_pulse", pulse_out, 32'd0);
        step();
        chk("done_one_cycle", done, 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 3'd0, 8'h5A, 8'h5A};
        vecs[1] = '{1'b1, 3'd1, 8'hA5, 8'hA5};
        vecs[2] = '{1'b1, 3'd2, 8'h07, 8'h07};
        vecs[3] = '{1'b1, 3'd3, 8'h02, 8'h01};
        vecs[4] = '{1'b1, 3'd3, 8'h00, 8'h00};
        vecs[5] = '{1'b1, 3'd4, 8'hFF, 8'h00};
        vecs[6] = '{1'b1, 3'd5, 8'h33, 8'h00};
        vecs[7] = '{1'b1, 3'd7, 8'h44, 8'h00};
        vecs[8] = '{1'b0, 3'd0, 8'h11, 8'h5A};
        vecs[9] = '{1'b0, 3'd6, 8'h22, 8'h00};

        // Reset state
        rst = 1'b1;
        step(); step();
        chk("rst_pulse", pulse_out, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_done", done, 32'd0);
        for (int a = 0; a < 8; a++) rd("rst_reg", a[2:0], 8'h00);
        rst = 1'b0;
        step();

        // Register map vectors
        for (int i = 0; i < 10; i++) begin
            cfg_we = vecs[i].we; cfg_addr = vecs[i].addr; cfg_wdata = vecs[i].wdata;
            step();
            cfg_we = 1'b0;
            #1;
            chk($sformatf("reg_vec%0d", i), cfg_rdata, vecs[i].exp);
        end

        // 4 periods of 3 high / 2 low with tick=1
        wr(3'd0, 8'd3); wr(3'd1, 8'd2); wr(3'd2, 8'd4);
        start_ctrl(8'h01);
        run_burst(3, 2, 4, 1, 1'b0, 3'd0, 8'd0);
        rd("sent_after_4", 3'd4, 8'd4);
        rd("ctrl_idle", 3'd3, 8'h00);

        // Zero lengths act as 1 tick; tick every 4th cycle
        tick_div = 4;
        wr(3'd0, 8'd0); wr(3'd1, 8'd0); wr(3'd2, 8'd1);
        start_ctrl(8'h01);
        run_burst(1, 1, 1, 4, 1'b0, 3'd0, 8'd0);
        rd("sent_after_1", 3'd4, 8'd1);
        tick_div = 1; tick = 1'b1;

        // HIGH_LEN rewritten mid-burst: readback immediate, effect next burst
        wr(3'd0, 8'd3); wr(3'd1, 8'd2); wr(3'd2, 8'd2);
        start_ctrl(8'h01);
        run_burst(3, 2, 2, 1, 1'b1, 3'd0, 8'd9);
        rd("high_len_new", 3'd0, 8'd9);
        start_ctrl(8'h01);
        run_burst(9, 2, 2, 1, 1'b0, 3'd0, 8'd0);

        // ARM + trig with abort stays idle; CTRL start with abort stays idle
        wr(3'd3, 8'h02);
        rd("ctrl_arm", 3'd3, 8'h01);
        trig = 1'b1; abort = 1'b1;
        step();
        trig = 1'b0; abort = 1'b0;
        chk("trig_abort_busy", busy, 32'd0);
        chk("trig_abort_pulse", pulse_out, 32'd0);
        abort = 1'b1;
        wr(3'd3, 8'h03);
        abort = 1'b0;
        chk("ctrl_abort_busy", busy, 32'd0);
        step();
        chk("idle_hold_busy", busy, 32'd0);
        trig = 1'b1;
        step();
        trig = 1'b0;
        chk("trig_start_busy", busy, 32'd1);
        chk("trig_start_pulse", pulse_out, 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("trig_abort2_busy", busy, 32'd0);
        wr(3'd3, 8'h00);

        // Continuous burst aborted after 7 periods; mid-burst CTRL start ignored
        wr(3'd0, 8'd2); wr(3'd1, 8'd1); wr(3'd2, 8'd0);
        start_ctrl(8'h01);
        for (int k = 0; k < 21; k++) begin
            chk("cont_pulse", pulse_out, ((k % 3) < 2) ? 32'd1 : 32'd0);
            chk("cont_done", done, 32'd0);
            if (k == 10) begin
                cfg_we = 1'b1; cfg_addr = 3'd3; cfg_wdata = 8'h01;
            end
            step();
            cfg_we = 1'b0;
        end
        rd("sent_7_busy", 3'd4, 8'd7);
        chk("cont_still_high", pulse_out, 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_pulse", pulse_out, 32'd0);
        chk("abort_busy", busy, 32'd0);
        chk("abort_done", done, 32'd0);
        rd("abort_sent", 3'd4, 8'd7);
        step();
        chk("abort_no_done", done, 32'd0);

        // SENT wraps after 256 periods in continuous mode
        wr(3'd0, 8'd1); wr(3'd1, 8'd1); wr(3'd2, 8'd0);
        start_ctrl(8'h01);
        for (int k = 0; k < 512; k++) begin
            if (done !== 1'b0) chk("wrap_done", done, 32'd0);
            step();
        end
        rd("sent_wrap0", 3'd4, 8'd0);
        rd("ctrl_busy", 3'd3, 8'h80);
        step(); step();
        rd("sent_wrap1", 3'd4, 8'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Reset mid-HIGH
        wr(3'd0, 8'd5); wr(3'd1, 8'd5); wr(3'd2, 8'd3); wr(3'd3, 8'h02);
        start_ctrl(8'h03);
        chk("pre_rst_pulse", pulse_out, 32'd1);
        step();
        chk("pre_rst_pulse2", pulse_out, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_pulse", pulse_out, 32'd0);
        chk("rst_mid_busy", busy, 32'd0);
        chk("rst_mid_done", done, 32'd0);
        for (int a = 0; a < 5; a++) rd("rst_mid_reg", a[2:0], 8'h00);
        for (int k = 0; k < 15; k++) begin
            chk("post_rst_done", done, 32'd0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
